alu_uart_ctrl: RTL and testbench
================================

# alu_uart_ctrl

Command sequencer between the UART receiver/transmitter pair and the combinational ALU. It parses an ASCII command stream into operand A, operand B and opcode Op. On an execute command it samples the ALU result and sends it back as one raw byte through the UART transmitter. It replaces direct operand decoding and closes the receive→compute→transmit loop.

## Interface
- DBIT, 8: data width of UART bytes, operands and result.
- OP_W, 6: ALU opcode width.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- rx_done_tick  in  1  one-cycle pulse; rx_dout holds a valid byte.
- rx_dout  in  DBIT  received byte.
- tx_done_tick  in  1  one-cycle pulse; transmitter finished the current byte.
- alu_res  in  DBIT  combinational ALU result for the current A, B and Op.
- A  out  DBIT  operand A register.
- B  out  DBIT  operand B register.
- Op  out  OP_W  opcode register.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_din.
- tx_din  out  DBIT  byte to transmit; held stable from the tx_start cycle until tx_done_tick.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky protocol error flag.

## Operation
- All outputs reset to 0. State resets to IDLE. Accumulator and digit count reset to 0.
- States: IDLE, EXEC, TX_START, TX_WAIT.
- Bytes are consumed only in IDLE, on the cycle rx_done_tick=1. Effects are visible after that edge.
- Digit '0'–'9' (0x30–0x39):
  - If digit count < 3: acc = acc*10 + (byte−0x30), truncated mod 256, and count += 1.
  - Otherwise: byte ignored and err set.
- 'A' (0x41): A ← acc. 'B' (0x42): B ← acc. Both then clear acc and count. With no digits entered, the register loads 0.
- Opcode characters set Op directly and leave acc untouched:
  - '+' (0x2B) → 32; '-' (0x2D) → 34; '&' (0x26) → 36; '|' (0x7C) → 37.
  - 'x' (0x78) → 38; 'a' (0x61) → 3; 'l' (0x6C) → 2; 'n' (0x6E) → 39.
- '=' (0x3D): IDLE → EXEC.
- 'C' (0x43): clears acc, count and err. A, B and Op are unchanged.
- Any other byte: ignored, err set.
- EXEC: tx_din ← alu_res, then go to TX_START.
- TX_START: tx_start=1 for exactly this cycle, then go to TX_WAIT.
- TX_WAIT: on tx_done_tick, go to IDLE.
- An rx byte arriving in EXEC, TX_START or TX_WAIT is dropped and err is set. This also applies when it coincides with tx_done_tick.

## Timing
- Latency from the '=' rx_done_tick cycle: EXEC at +1, tx_start high at +2, TX_WAIT from +3.
- A, B and Op are constant from EXEC until the return to IDLE, so alu_res is stable when sampled.
- tx_start is never reasserted before tx_done_tick.
- Back-to-back rx_done_tick pulses in consecutive IDLE cycles are each processed.
- A byte arriving in the same cycle IDLE is re-entered (the cycle after tx_done_tick) is processed normally.
- Reset assertion in any state forces all outputs to 0 immediately (asynchronous), including mid-TX_WAIT. A transmitter already started is not aborted by this block.

## Structure
- Shared package alu_uart_pkg holds:
  - the ASCII command constants;
  - the eight opcode constants (32, 34, 36, 37, 38, 3, 2, 39);
  - the state encoding: 2 bits, IDLE=0, EXEC=1, TX_START=2, TX_WAIT=3.
- Sub-module dec_accum holds acc, the digit count, the mod-256 multiply-add and the overflow error. Its controls are load-digit, clear and count_full. The FSM stays in alu_uart_ctrl.

## Test plan
- "12A34B+=" with ALU model (A+B): A=12, B=34, Op=32; one tx_start with tx_din=46. After tx_done_tick, busy=0 and err=0.
- "300A": A=44 (mod 256). Then "1234B": B=123 and err=1. Then "C": err=0, A and B unchanged.
- "5A3B-=" then "7" sent during TX_WAIT: tx_din=2, err=1, acc still 0 ('A' after transmit loads 0).
- Opcode chars "&|xaln" each followed by '=': Op sequence 36, 37, 38, 3, 2, 39, with tx_din equal to the model result each time. 'z' sets err and leaves Op unchanged.
- Reset asserted (0) during TX_WAIT: A=B=Op=0, tx_din=0, busy=0, err=0 while reset is held. After release, "9A" gives A=9.

Source files
------------

// File: rtl/alu_uart_pkg.sv
// Shared constants for the ALU/UART command sequencer: ASCII command bytes,
// ALU opcode values and the controller state encoding.
package alu_uart_pkg;

    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_9   = 8'h39;
    localparam logic [7:0] CH_A   = 8'h41;
    localparam logic [7:0] CH_B   = 8'h42;
    localparam logic [7:0] CH_C   = 8'h43;
    localparam logic [7:0] CH_EQ  = 8'h3D;
    localparam logic [7:0] CH_ADD = 8'h2B;
    localparam logic [7:0] CH_SUB = 8'h2D;
    localparam logic [7:0] CH_AND = 8'h26;
    localparam logic [7:0] CH_OR  = 8'h7C;
    localparam logic [7:0] CH_XOR = 8'h78;
    localparam logic [7:0] CH_SRA = 8'h61;
    localparam logic [7:0] CH_SRL = 8'h6C;
    localparam logic [7:0] CH_NOR = 8'h6E;

    localparam logic [5:0] OP_ADD = 6'd32;
    localparam logic [5:0] OP_SUB = 6'd34;
    localparam logic [5:0] OP_AND = 6'd36;
    localparam logic [5:0] OP_OR  = 6'd37;
    localparam logic [5:0] OP_XOR = 6'd38;
    localparam logic [5:0] OP_SRA = 6'd3;
    localparam logic [5:0] OP_SRL = 6'd2;
    localparam logic [5:0] OP_NOR = 6'd39;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_TX_START = 2'd2,
        ST_TX_WAIT  = 2'd3
    } state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal operand accumulator: up to three digits folded into acc*10+digit,
// wrapping modulo 2^DBIT.
module dec_accum
    import alu_uart_pkg::*;
#(
    parameter int DBIT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_digit,
    input  logic [3:0]      digit,
    input  logic            clear,
    output logic [DBIT-1:0] acc,
    output logic            count_full
);

    logic [DBIT-1:0] acc_reg;
    logic [1:0]      count_reg;

    assign count_full = (count_reg == 2'd3);
    assign acc        = acc_reg;

    // A digit offered while full is dropped here; the caller flags the error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg   <= '0;
            count_reg <= '0;
        end else if (clear) begin
            acc_reg   <= '0;
            count_reg <= '0;
        end else if (load_digit && !count_full) begin
            acc_reg   <= acc_reg * DBIT'(10) + DBIT'(digit);
            count_reg <= count_reg + 2'd1;
        end
    end

endmodule

// File: rtl/alu_uart_ctrl.sv
// Command sequencer: parses ASCII operands/opcodes from the UART receiver,
// and on '=' returns the ALU result as one byte through the transmitter.
module alu_uart_ctrl
    import alu_uart_pkg::*;
#(
    parameter int DBIT = 8,
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_done_tick,
    input  logic [DBIT-1:0] rx_dout,
    input  logic            tx_done_tick,
    input  logic [DBIT-1:0] alu_res,
    output logic [DBIT-1:0] A,
    output logic [DBIT-1:0] B,
    output logic [OP_W-1:0] Op,
    output logic            tx_start,
    output logic [DBIT-1:0] tx_din,
    output logic            busy,
    output logic            err
);

    state_t state_reg, state_next;

    logic [DBIT-1:0] a_reg, b_reg, tx_din_reg, acc;
    logic [OP_W-1:0] op_reg, op_next;
    logic            err_reg;
    logic            load_digit, acc_clear, count_full;
    logic            load_a, load_b, op_load, tx_load, err_set, err_clr;

    dec_accum #(.DBIT(DBIT)) u_dec_accum (
        .clk        (clk),
        .reset      (reset),
        .load_digit (load_digit),
        .digit      (rx_dout[3:0]),
        .clear      (acc_clear),
        .acc        (acc),
        .count_full (count_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        load_digit = 1'b0;
        acc_clear  = 1'b0;
        load_a     = 1'b0;
        load_b     = 1'b0;
        op_load    = 1'b0;
        op_next    = op_reg;
        tx_load    = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (rx_done_tick) begin
                    if (is_digit(8'(rx_dout))) begin
                        load_digit = 1'b1;
                        err_set    = count_full;
                    end else begin
                        op_load = 1'b1;
                        case (8'(rx_dout))
                            CH_ADD:  op_next = OP_W'(OP_ADD);
                            CH_SUB:  op_next = OP_W'(OP_SUB);
                            CH_AND:  op_next = OP_W'(OP_AND);
                            CH_OR:   op_next = OP_W'(OP_OR);
                            CH_XOR:  op_next = OP_W'(OP_XOR);
                            CH_SRA:  op_next = OP_W'(OP_SRA);
                            CH_SRL:  op_next = OP_W'(OP_SRL);
                            CH_NOR:  op_next = OP_W'(OP_NOR);
                            default: op_load = 1'b0;
                        endcase
                        case (8'(rx_dout))
                            CH_A:  begin load_a = 1'b1; acc_clear = 1'b1; end
                            CH_B:  begin load_b = 1'b1; acc_clear = 1'b1; end
                            CH_C:  begin acc_clear = 1'b1; err_clr = 1'b1; end
                            CH_EQ: state_next = ST_EXEC;
                            default: err_set = !op_load;
                        endcase
                    end
                end
            end
            ST_EXEC: begin
                tx_load    = 1'b1;
                state_next = ST_TX_START;
            end
            ST_TX_START: state_next = ST_TX_WAIT;
            ST_TX_WAIT: if (tx_done_tick) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        // Bytes arriving while a result is in flight are lost.
        if (state_reg != ST_IDLE && rx_done_tick) err_set = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            tx_din_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (load_a)  a_reg      <= acc;
            if (load_b)  b_reg      <= acc;
            if (op_load) op_reg     <= op_next;
            if (tx_load) tx_din_reg <= alu_res;
            if (err_clr)      err_reg <= 1'b0;
            else if (err_set) err_reg <= 1'b1;
        end
    end

    assign A        = a_reg;
    assign B        = b_reg;
    assign Op       = op_reg;
    assign tx_din   = tx_din_reg;
    assign tx_start = (state_reg == ST_TX_START);
    assign busy     = (state_reg != ST_IDLE);
    assign err      = err_reg;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl: byte-stream stimulus, behavioural ALU and
// transmitter, and a scoreboard checking every transmitted result byte.
module tb_alu_uart_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_dout = 8'h00;
    logic       tx_done_tick = 1'b0;
    logic [7:0] alu_res;
    logic [7:0] A, B, tx_din;
    logic [5:0] Op;
    logic       tx_start, busy, err;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [7:0] exp_q[$];

    alu_uart_ctrl #(.DBIT(8), .OP_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_dout      (rx_dout),
        .tx_done_tick (tx_done_tick),
        .alu_res      (alu_res),
        .A            (A),
        .B            (B),
        .Op           (Op),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        case (Op)
            6'd32:   alu_res = A + B;
            6'd34:   alu_res = A - B;
            6'd36:   alu_res = A & B;
            6'd37:   alu_res = A | B;
            6'd38:   alu_res = A ^ B;
            6'd3:    alu_res = 8'($signed(A) >>> B);
            6'd2:    alu_res = A >> B;
            6'd39:   alu_res = ~(A | B);
            default: alu_res = 8'h00;
        endcase
    end

    task automatic check(input string name, input int act, input int expv);
        chk_cnt++;
        if (act == expv) pass_cnt++;
        else $display("FAIL %s: got %0d, required %0d", name, act, expv);
    endtask

    // Transmitter model: finishes each byte a fixed number of cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) begin
                repeat (8) @(negedge clk);
                tx_done_tick = 1'b1;
                @(negedge clk);
                tx_done_tick = 1'b0;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (reset && tx_start) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_tx_start", 1, 0);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("tx_din", int'(tx_din), int'(e));
                    $display("tx byte %0d (expected %0d)", tx_din, e);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_dout      = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        $display("rx byte 0x%02h", b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("return_to_idle", int'(busy), 0);
    endtask

    initial begin
        logic [5:0] op_seq[6];
        logic [7:0] res_seq[6];
        string      op_chr;
        op_seq  = '{6'd36, 6'd37, 6'd38, 6'd3, 6'd2, 6'd39};
        res_seq = '{8'd2, 8'd203, 8'd201, 8'd249, 8'd25, 8'd52};
        op_chr  = "&|xaln";

        repeat (3) @(negedge clk);
        check("rst_A", int'(A), 0);
        check("rst_B", int'(B), 0);
        check("rst_Op", int'(Op), 0);
        check("rst_tx_din", int'(tx_din), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        check("rst_tx_start", int'(tx_start), 0);
        reset = 1'b1;

        // 12 + 34
        exp_q.push_back(8'd46);
        send_str("12A34B+=");
        check("busy_after_eq", int'(busy), 1);
        wait_idle();
        check("add_A", int'(A), 12);
        check("add_B", int'(B), 34);
        check("add_Op", int'(Op), 32);
        check("add_err", int'(err), 0);

        // Wrap-around and digit overflow
        send_str("300A");
        check("wrap_A", int'(A), 44);
        send_str("1234B");
        check("ovf_B", int'(B), 123);
        check("ovf_err", int'(err), 1);
        send_str("C");
        check("clr_err", int'(err), 0);
        check("clr_A", int'(A), 44);
        check("clr_B", int'(B), 123);

        // Byte during TX_WAIT is dropped
        exp_q.push_back(8'd2);
        send_str("5A3B-=");
        repeat (2) @(negedge clk);
        send_byte("7");
        check("drop_err", int'(err), 1);
        wait_idle();
        check("sub_Op", int'(Op), 34);
        send_str("A");
        check("drop_acc_A", int'(A), 0);

        // Remaining opcodes on A=202, B=3
        send_str("C202A3B");
        check("op_A", int'(A), 202);
        check("op_B", int'(B), 3);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(res_seq[i]);
            send_byte(op_chr[i]);
            check($sformatf("op_%0d", i), int'(Op), int'(op_seq[i]));
            send_str("=");
            wait_idle();
        end
        send_str("z");
        check("bad_err", int'(err), 1);
        check("bad_Op", int'(Op), 39);

        // Asynchronous reset during TX_WAIT
        exp_q.push_back(8'd52);
        send_str("=");
        repeat (3) @(negedge clk);
        check("pre_rst_busy", int'(busy), 1);
        #2 reset = 1'b0;
        #1;
        check("arst_A", int'(A), 0);
        check("arst_B", int'(B), 0);
        check("arst_Op", int'(Op), 0);
        check("arst_tx_din", int'(tx_din), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_err", int'(err), 0);
        check("arst_tx_start", int'(tx_start), 0);
        @(negedge clk);
        reset = 1'b1;
        send_str("9A");
        check("post_rst_A", int'(A), 9);

        repeat (20) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
